// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, bubble word,
// fetch FSM states and fault codes.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

  function automatic logic misaligned(
    input logic [XLEN-1:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/ack handshake with
// read data valid in the ack cycle.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter with clear/enable; term_o flags
// that the count has reached MAX.
module fetch_timeout_ctr #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] cnt_q;

  assign term_o = (cnt_q == MAXV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !term_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads words over a req/ack port,
// bubbles with NOPs while waiting and traps bad PCs/timeouts.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  initialPCval,
  input  logic [XLEN-1:0]  next_pc,
  input  logic             pause,
  instr_fetch_unit_if.master mem,
  output logic [XLEN-1:0]  instruction_word,
  output logic             instr_valid,
  output logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             fault,
  output logic [1:0]       fault_code
);

  fetch_state_e     state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  word_q;
  logic             valid_q;
  logic [CNT_W-1:0] issued_q;
  logic             fault_q;
  logic [1:0]       code_q;

  logic in_fetch;
  logic tmo_term;

  assign in_fetch     = (state_q == FETCH);
  assign mem.mem_req  = in_fetch;
  assign mem.mem_addr = pc_q;

  fetch_timeout_ctr #(
    .MAX (TIMEOUT - 1)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (!in_fetch || mem.mem_ack),
    .en_i   (in_fetch),
    .term_o (tmo_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      pc_q     <= '0;
      word_q   <= NOP_WORD;
      valid_q  <= 1'b0;
      issued_q <= '0;
      fault_q  <= 1'b0;
      code_q   <= FLT_NONE;
    end else begin
      unique case (state_q)
        BOOT: begin
          pc_q <= initialPCval;
          if (misaligned(initialPCval)) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            code_q  <= FLT_MISALIGN;
          end else begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (mem.mem_ack) begin
            word_q  <= mem.mem_rdata;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end else if (tmo_term) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            code_q  <= FLT_TIMEOUT;
          end
        end
        ISSUE: begin
          if (!pause) begin
            // consumed: count it even if the redirect traps
            word_q   <= NOP_WORD;
            valid_q  <= 1'b0;
            issued_q <= issued_q + CNT_W'(1);
            pc_q     <= next_pc;
            if (misaligned(next_pc)) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
              code_q  <= FLT_MISALIGN;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= FAULT;
        end
      endcase
    end
  end

  assign instruction_word = word_q;
  assign instr_valid      = valid_q;
  assign pc               = pc_q;
  assign issued_cnt       = issued_q;
  assign fault            = fault_q;
  assign fault_code       = code_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector
// table plus hand-written reset/timeout/boot-fault sequences.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] initialPCval;
  logic [31:0] next_pc;
  logic        pause;
  logic [31:0] instruction_word;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] issued_cnt;
  logic        fault;
  logic [1:0]  fault_code;

  instr_fetch_unit_if mif ();

  instr_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .initialPCval     (initialPCval),
    .next_pc          (next_pc),
    .pause            (pause),
    .mem              (mif),
    .instruction_word (instruction_word),
    .instr_valid      (instr_valid),
    .pc               (pc),
    .issued_cnt       (issued_cnt),
    .fault            (fault),
    .fault_code       (fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        pause;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] npc;
    logic        req;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] word;
    logic [31:0] cnt;
    logic        flt;
    logic [1:0]  code;
  } vec_t;

  vec_t v[17];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_row(input int i);
    string s;
    s = $sformatf("row%0d", i);
    chk({s, ".req"},   32'(mif.mem_req), 32'(v[i].req));
    chk({s, ".addr"},  mif.mem_addr, v[i].pc);
    chk({s, ".pc"},    pc, v[i].pc);
    chk({s, ".valid"}, 32'(instr_valid), 32'(v[i].valid));
    chk({s, ".word"},  instruction_word, v[i].word);
    chk({s, ".cnt"},   issued_cnt, v[i].cnt);
    chk({s, ".fault"}, 32'(fault), 32'(v[i].flt));
    chk({s, ".code"},  32'(fault_code), 32'(v[i].code));
  endtask

  int n;

  initial begin
    // pause ack rdata npc | req pc valid word cnt flt code
    v[0]  = '{0,0,32'h0,32'h0,          0,32'h0, 0,NOP,0,0,2'b00};
    v[1]  = '{0,1,32'h00A00113,32'h0,   1,32'h0, 0,NOP,0,0,2'b00};
    v[2]  = '{0,0,32'h0,32'h4,          0,32'h0, 1,32'h00A00113,0,0,2'b00};
    v[3]  = '{0,0,32'h0,32'h0,          1,32'h4, 0,NOP,1,0,2'b00};
    v[4]  = '{0,0,32'h0,32'h0,          1,32'h4, 0,NOP,1,0,2'b00};
    v[5]  = '{0,0,32'h0,32'h0,          1,32'h4, 0,NOP,1,0,2'b00};
    v[6]  = '{0,1,32'h00E00193,32'h0,   1,32'h4, 0,NOP,1,0,2'b00};
    v[7]  = '{1,1,32'hBAD0BAD0,32'h44,  0,32'h4, 1,32'h00E00193,1,0,2'b00};
    v[8]  = '{1,0,32'h0,32'h44,         0,32'h4, 1,32'h00E00193,1,0,2'b00};
    v[9]  = '{1,0,32'h0,32'h44,         0,32'h4, 1,32'h00E00193,1,0,2'b00};
    v[10] = '{1,0,32'h0,32'h44,         0,32'h4, 1,32'h00E00193,1,0,2'b00};
    v[11] = '{1,0,32'h0,32'h44,         0,32'h4, 1,32'h00E00193,1,0,2'b00};
    v[12] = '{0,0,32'h0,32'h10,         0,32'h4, 1,32'h00E00193,1,0,2'b00};
    v[13] = '{0,1,32'h00100093,32'h0,   1,32'h10,0,NOP,2,0,2'b00};
    v[14] = '{0,0,32'h0,32'hE,          0,32'h10,1,32'h00100093,2,0,2'b00};
    v[15] = '{0,1,32'hDEADBEEF,32'h0,   0,32'hE, 0,NOP,3,1,2'b01};
    v[16] = '{0,0,32'h0,32'h20,         0,32'hE, 0,NOP,3,1,2'b01};

    rst           = 1'b0;
    initialPCval  = 32'h0;
    next_pc       = 32'h0;
    pause         = 1'b0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst.req",  32'(mif.mem_req), 32'd0);
    chk("rst.word", instruction_word, NOP);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      pause         = v[i].pause;
      mif.mem_ack   = v[i].ack;
      mif.mem_rdata = v[i].rdata;
      next_pc       = v[i].npc;
      #1;
      chk_row(i);
      @(negedge clk);
    end
    mif.mem_ack = 1'b0;

    // misaligned boot PC traps straight out of BOOT
    rst          = 1'b0;
    initialPCval = 32'h102;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mboot.fault", 32'(fault), 32'd1);
    chk("mboot.code",  32'(fault_code), 32'd1);
    chk("mboot.pc",    pc, 32'h102);
    chk("mboot.req",   32'(mif.mem_req), 32'd0);

    // memory never acks
    @(negedge clk);
    rst          = 1'b0;
    initialPCval = 32'h100;
    @(negedge clk);
    rst = 1'b1;
    n   = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (fault) break;
      if (mif.mem_req) n++;
    end
    chk("tmo.reqcycles", 32'(n), 32'd16);
    chk("tmo.fault",     32'(fault), 32'd1);
    chk("tmo.code",      32'(fault_code), 32'd2);
    chk("tmo.pc",        pc, 32'h100);
    chk("tmo.req",       32'(mif.mem_req), 32'd0);

    // one-cycle reset pulse clears all, BOOT reloads PC
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("pulse.fault", 32'(fault), 32'd0);
    chk("pulse.code",  32'(fault_code), 32'd0);
    chk("pulse.pc",    pc, 32'h0);
    chk("pulse.cnt",   issued_cnt, 32'h0);
    @(negedge clk);
    rst          = 1'b1;
    initialPCval = 32'h200;
    @(negedge clk);
    #1;
    chk("reboot.req",  32'(mif.mem_req), 32'd1);
    chk("reboot.addr", mif.mem_addr, 32'h200);

    // async reset between edges while req is high
    #2;
    rst           = 1'b0;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h12345678;
    #1;
    chk("async.req",   32'(mif.mem_req), 32'd0);
    chk("async.valid", 32'(instr_valid), 32'd0);
    chk("async.pc",    pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("late.req",   32'(mif.mem_req), 32'd0);
    chk("late.valid", 32'(instr_valid), 32'd0);
    chk("late.word",  instruction_word, NOP);
    @(negedge clk);
    #1;
    chk("late.pc",    pc, 32'h200);
    chk("late.valid2", 32'(instr_valid), 32'd0);
    mif.mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies `instruction_word` to the DataPath, which consumes it.
- Owns the fetch PC and takes the next PC back from the DataPath (`Addition_result`).
- Reads instruction words from a variable-latency instruction memory over a req/ack handshake.
- Inserts NOP bubbles while a fetch is outstanding, honours `pause`, and traps misaligned PCs and memory timeouts.

Parameters:
- NOP_WORD, 32'h00000013, bubble word (ADDI x0,x0,0) driven whenever no valid instruction is held.
- TIMEOUT, 16, maximum cycles `mem_req` may stay high without `mem_ack` before a fault.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- initialPCval  in  32  boot PC, sampled in the BOOT cycle.
- next_pc  in  32  next PC from the DataPath (`Addition_result`), sampled when an instruction is consumed.
- pause  in  1  DataPath stall; 1 = do not consume the current instruction.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  32  word-aligned read address; equals the PC.
- mem_ack  in  1  memory acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  instruction word from memory.
- instruction_word  out  32  instruction to the DataPath; NOP_WORD when `instr_valid`=0.
- instr_valid  out  1  `instruction_word` holds a fetched instruction.
- pc  out  32  address of the instruction currently held or being fetched.
- issued_cnt  out  CNT_W  number of instructions consumed since reset.
- fault  out  1  sticky error flag.
- fault_code  out  2  00 none, 01 misaligned PC, 10 memory timeout.

Behaviour:
- Reset (`rst`=0, asynchronous): state=BOOT, pc=0, `mem_req`=0, `instr_valid`=0, `instruction_word`=NOP_WORD, `issued_cnt`=0, `fault`=0, `fault_code`=00, timeout counter=0.
- Reset asserted mid-fetch abandons the request immediately; a late `mem_ack` is ignored after reset.
- BOOT: one cycle. pc <= initialPCval, then → FETCH.
  - If initialPCval[1:0]≠0: → FAULT with code 01.
- FETCH: `mem_req`=1, `mem_addr`=pc, `instr_valid`=0, output NOP_WORD.
  - Timeout counter increments each cycle `mem_ack`=0.
  - At an edge with `mem_ack`=1: latch `mem_rdata`, clear the counter, → ISSUE.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
  - Counter reaching TIMEOUT-1 without ack: → FAULT with code 10.
  - `pause` has no effect in FETCH.
- ISSUE: `mem_req`=0, `instr_valid`=1, `instruction_word`=latched word.
  - `pause`=1: hold the word and pc unchanged, indefinitely.
  - `pause`=0 at the edge: the instruction is consumed. pc <= next_pc, `issued_cnt`+1 (wraps modulo 2^CNT_W), → FETCH.
  - If next_pc[1:0]≠0 at consumption: `issued_cnt` still increments, pc <= next_pc, → FAULT with code 01.
- FAULT: terminal until reset. `mem_req`=0, `instr_valid`=0, NOP_WORD driven, `fault`=1, `fault_code` held, pc frozen at the offending address.
- Throughput: with zero-wait memory, one instruction per 2 cycles. Each FETCH-state cycle contributes exactly one NOP cycle on `instruction_word`.
- A memory ack while `mem_req`=0 is ignored.
- All outputs are registered, except `mem_addr` (= pc register) and `mem_req`, which are decoded from the state register.

Decomposition:
- Shared package `cpu_pkg`:
  - NOP_WORD constant.
  - fetch state enum: BOOT, FETCH, ISSUE, FAULT.
  - fault code constants: FLT_NONE, FLT_MISALIGN, FLT_TIMEOUT.
  - XLEN=32.
- One natural sub-module, `fetch_timeout_ctr`: a saturating counter with clear/enable and a terminal flag, reusable for a future data-memory port.

Test Plan:
- Boot and zero-wait fetch:
  - Stimulus: initialPCval=0; memory acks immediately with 0x00A00113 (ADDI x2,x0,10); pause=0; next_pc=pc+4.
  - Required: `mem_addr`=0 in FETCH, then `instruction_word`=0x00A00113 with `instr_valid`=1 for one cycle, then `mem_addr`=4; `issued_cnt`=1.
- Wait states:
  - Stimulus: memory acks 3 cycles after req, returning 0x00E00193.
  - Required: NOP_WORD for 4 cycles, then 0x00E00193 for 1 cycle; `mem_req` drops the cycle after ack.
- Pause hold:
  - Stimulus: pause=1 for 5 cycles during ISSUE.
  - Required: word and pc stable for 5 cycles, `issued_cnt` unchanged.
  - Then: after pause=0, pc <= next_pc (e.g. 0x10, a jump target) and the next `mem_addr`=0x10.
- Misaligned redirect:
  - Stimulus: next_pc=0x0000000E at consumption.
  - Required: `fault`=1, `fault_code`=01, pc=0xE, `mem_req` stays 0, NOP_WORD driven.
- Timeout:
  - Stimulus: memory never acks.
  - Required: after TIMEOUT cycles, `fault`=1 and `fault_code`=10.
  - Then: rst pulsed low for one cycle clears everything, and BOOT reloads initialPCval.
- Asynchronous reset mid-fetch:
  - Stimulus: rst low between edges while `mem_req`=1.
  - Required: `mem_req`=0 and `instr_valid`=0 immediately, without waiting for a clock edge.
